// File: rtl/int_if_pkg.sv
// Shared encodings, field widths and FSM state type for the int_* transaction interface.
// Consumed by the responder top level and its storage sub-module.
package int_if_pkg;

   localparam logic [1:0] INT_SIZE_1 = 2'b00;
   localparam logic [1:0] INT_SIZE_2 = 2'b01;
   localparam logic [1:0] INT_SIZE_4 = 2'b10;
   localparam logic [1:0] INT_SIZE_8 = 2'b11;

   localparam int INT_DATA_MSB = 31;
   localparam int INT_AD_W     = 39;

   typedef enum logic [1:0] {IDLE, WR_DATA, RD_WAIT, RD_DATA} resp_state_t;

   // Per-transaction context latched from the address beat.
   typedef struct packed {
      logic [2:0] last_beat;
      logic       dir;
   } tran_ctx_t;

   function automatic logic [3:0] nbeats(input logic [1:0] size);
      return 4'd1 << size;
   endfunction

endpackage

// File: rtl/int_resp_mem.sv
// DEPTH x 32 word store: one synchronous write port, one combinational read port.
// Zero-latency read, write lands on the clock edge; no backpressure (always accepts).
module int_resp_mem
   import int_if_pkg::*;
#(
   parameter  int DEPTH  = 256,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic                    clk,
   input  logic                    i_wr_en,
   input  logic [ADDR_W-1:0]       i_wr_addr,
   input  logic [INT_DATA_MSB:0]   i_wr_dat,
   input  logic [ADDR_W-1:0]       i_rd_addr,
   output logic [INT_DATA_MSB:0]   o_rd_dat
);

   logic [INT_DATA_MSB:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_dat;
      end
   end

   assign o_rd_dat = r_mem[i_rd_addr];

endmodule

// File: rtl/int_responder.sv
// Responder end of the int_* stream: address beat then 1/2/4/8 data beats into local word memory.
// All outputs registered; reads pause int_ready for max(RD_LATENCY,1) cycles, requester stalls via int_valid.
module int_responder
   import int_if_pkg::*;
#(
   parameter int DEPTH      = 256,
   parameter int RD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  int_valid,
   input  logic                  trans_started,
   input  logic                  int_read_write,
   input  logic                  current_read_write,
   input  logic [1:0]            int_size,
   input  logic [INT_AD_W-1:0]   int_addr_data,
   output logic                  int_ready,
   output logic                  new_tran,
   output logic [INT_DATA_MSB:0] int2ig_data,
   output logic                  int_read_done,
   output logic                  proto_err
);

   localparam int ADDR_W = $clog2(DEPTH);

   resp_state_t           r_state;
   tran_ctx_t             r_ctx;
   logic [ADDR_W-1:0]     r_base;
   logic [2:0]            r_beat_cnt;
   logic [3:0]            r_wait_cnt;
   logic                  r_ready;
   logic                  r_new_tran;
   logic [INT_DATA_MSB:0] r_rdata;
   logic                  r_read_done;
   logic                  r_proto_err;

   logic                  w_xfer;
   logic                  w_last;
   logic [2:0]            w_beat_nxt;
   logic                  w_wr_en;
   logic [ADDR_W-1:0]     w_wr_addr;
   logic [ADDR_W-1:0]     w_rd_addr;
   logic [INT_DATA_MSB:0] w_rd_dat;
   logic                  w_in_data;
   logic                  w_unused;

   assign w_unused   = ^int_addr_data[INT_AD_W-1:INT_DATA_MSB+1];

   assign w_xfer     = int_valid & r_ready;
   assign w_last     = (r_beat_cnt == r_ctx.last_beat);
   assign w_beat_nxt = r_beat_cnt + 3'd1;
   assign w_in_data  = (r_state == WR_DATA) || (r_state == RD_DATA);
   assign w_wr_en    = rst_n & w_xfer & (r_state == WR_DATA);
   assign w_wr_addr  = r_base + ADDR_W'(r_beat_cnt);
   // RD_WAIT prefetches the base word; RD_DATA looks one beat ahead so the reload lands with the transfer.
   assign w_rd_addr  = (r_state == RD_DATA) ? r_base + ADDR_W'(w_beat_nxt) : r_base;

   int_resp_mem #(.DEPTH(DEPTH)) u_mem (
      .clk       (clk),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (w_wr_addr),
      .i_wr_dat  (int_addr_data[INT_DATA_MSB:0]),
      .i_rd_addr (w_rd_addr),
      .o_rd_dat  (w_rd_dat)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_ctx       <= '0;
         r_base      <= '0;
         r_beat_cnt  <= '0;
         r_wait_cnt  <= '0;
         r_ready     <= 1'b0;
         r_new_tran  <= 1'b0;
         r_rdata     <= '0;
         r_read_done <= 1'b0;
         r_proto_err <= 1'b0;
      end else begin
         r_new_tran <= 1'b0;

         if ((r_state != IDLE) && int_valid && trans_started) begin
            r_proto_err <= 1'b1;
         end
         if (w_in_data && int_valid && (current_read_write != r_ctx.dir)) begin
            r_proto_err <= 1'b1;
         end

         case (r_state)
            IDLE: begin
               r_ready <= 1'b1;
               if (w_xfer) begin
                  if (trans_started) begin
                     r_base        <= int_addr_data[ADDR_W+1:2];
                     r_ctx.last_beat <= 3'(nbeats(int_size) - 4'd1);
                     r_ctx.dir     <= int_read_write;
                     r_beat_cnt    <= '0;
                     r_new_tran    <= 1'b1;
                     if (int_read_write) begin
                        r_state    <= RD_WAIT;
                        r_wait_cnt <= 4'(RD_LATENCY);
                        r_ready    <= 1'b0;
                     end else begin
                        r_state    <= WR_DATA;
                     end
                  end else begin
                     r_proto_err <= 1'b1;
                  end
               end
            end

            WR_DATA: begin
               if (w_xfer) begin
                  if (w_last) begin
                     r_state    <= IDLE;
                     r_beat_cnt <= '0;
                  end else begin
                     r_beat_cnt <= w_beat_nxt;
                  end
               end
            end

            RD_WAIT: begin
               // Leaving on a count of 1 gives RD_LATENCY dead cycles; 0 still costs the one prefetch cycle.
               if (r_wait_cnt <= 4'd1) begin
                  r_state     <= RD_DATA;
                  r_wait_cnt  <= '0;
                  r_ready     <= 1'b1;
                  r_rdata     <= w_rd_dat;
                  r_read_done <= (r_ctx.last_beat == 3'd0);
               end else begin
                  r_wait_cnt  <= r_wait_cnt - 4'd1;
               end
            end

            RD_DATA: begin
               if (w_xfer) begin
                  if (w_last) begin
                     r_state     <= IDLE;
                     r_beat_cnt  <= '0;
                     r_read_done <= 1'b0;
                  end else begin
                     r_beat_cnt  <= w_beat_nxt;
                     r_rdata     <= w_rd_dat;
                     r_read_done <= (w_beat_nxt == r_ctx.last_beat);
                  end
               end
            end

            default: begin
               r_state <= IDLE;
               r_ready <= 1'b0;
            end
         endcase
      end
   end

   assign int_ready     = r_ready;
   assign new_tran      = r_new_tran;
   assign int2ig_data   = r_rdata;
   assign int_read_done = r_read_done;
   assign proto_err     = r_proto_err;

endmodule
